mouse_packet_assembler: RTL

- Producer side of the mouse data interface. Consumes the byte stream from the PS/2 serial receiver and assembles standard 3-byte streaming-mode packets (status, DX, DY).
- Publishes each packet as MOUSE_STATUS/MOUSE_DX/MOUSE_DY plus an INTERRUPT level pulse. The mouse position calculator and the processor interrupt logic consume these outputs.
- Provides resynchronisation, inter-byte timeout and a one-deep pending buffer, so the consumer never sees data change while INTERRUPT is high.

---
 rtl/mouse_packet_assembler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mouse_packet_assembler.sv
// Assembles 3-byte PS/2 streaming packets (status, DX, DY) and publishes them
// with a fixed-length INTERRUPT pulse, holding one further packet in a pending buffer.
module mouse_packet_assembler #(
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter int INT_HIGH_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       INTERRUPT,
  output logic [7:0] SYNC_ERR_COUNT
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INT_HIGH_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] INT_LAST = IW'(INT_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_STATUS, WAIT_DX, WAIT_DY} state_t;

  state_t        state_q, state_d;
  logic [7:0]    status_q, status_d, dx_q, dx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    out_st_q, out_st_d, out_dx_q, out_dx_d, out_dy_q, out_dy_d;
  logic          arm_q, arm_d, int_q, int_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic          pend_v_q, pend_v_d;
  logic [7:0]    pend_st_q, pend_st_d, pend_dx_q, pend_dx_d, pend_dy_q, pend_dy_d;
  logic [7:0]    err_q, err_d;

  logic       pkt_done, err_evt, ovr_evt, busy;
  logic [7:0] pkt_dx, pkt_dy;

  // Receive FSM: byte acceptance, resync and inter-byte timeout.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    dx_d     = dx_q;
    tmo_d    = tmo_q;
    pkt_done = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = {TW{1'b0}};
        if (ENABLE) state_d = WAIT_STATUS;
        else        state_d = IDLE;
      end
      WAIT_STATUS: begin
        tmo_d = {TW{1'b0}};
        if (BYTE_VALID) begin
          if (!BYTE_ERROR && BYTE_IN[3]) begin
            status_d = BYTE_IN;
            state_d  = WAIT_DX;
          end else begin
            err_evt = 1'b1;
          end
        end else begin
          state_d = WAIT_STATUS;
        end
      end
      WAIT_DX, WAIT_DY: begin
        if (BYTE_VALID) begin
          tmo_d = {TW{1'b0}};
          if (BYTE_ERROR) begin
            err_evt = 1'b1;
            state_d = WAIT_STATUS;
          end else if (state_q == WAIT_DX) begin
            dx_d    = BYTE_IN;
            state_d = WAIT_DY;
          end else begin
            pkt_done = 1'b1;
            state_d  = WAIT_STATUS;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = {TW{1'b0}};
          err_evt = 1'b1;
          state_d = WAIT_STATUS;
        end else begin
          tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
    // Streaming disabled: drop any partial packet silently.
    if (!ENABLE) begin
      state_d  = IDLE;
      tmo_d    = {TW{1'b0}};
      pkt_done = 1'b0;
      err_evt  = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign pkt_dx = status_q[6] ? 8'h00 : dx_q;
  assign pkt_dy = status_q[7] ? 8'h00 : BYTE_IN;
  assign busy   = arm_q | int_q;

  // Publish sequencing, pending buffer and error counter.
  always_comb begin
    out_st_d  = out_st_q;
    out_dx_d  = out_dx_q;
    out_dy_d  = out_dy_q;
    arm_d     = 1'b0;
    int_d     = int_q;
    icnt_d    = icnt_q;
    pend_v_d  = pend_v_q;
    pend_st_d = pend_st_q;
    pend_dx_d = pend_dx_q;
    pend_dy_d = pend_dy_q;
    err_d     = err_q;
    ovr_evt   = 1'b0;

    if (arm_q) begin
      int_d  = 1'b1;
      icnt_d = INT_LAST;
    end else if (int_q) begin
      if (icnt_q == {IW{1'b0}}) int_d  = 1'b0;
      else                      icnt_d = icnt_q - {{(IW-1){1'b0}}, 1'b1};
    end else begin
      int_d = 1'b0;
    end

    if (!busy && pend_v_q) begin
      out_st_d = pend_st_q;
      out_dx_d = pend_dx_q;
      out_dy_d = pend_dy_q;
      arm_d    = 1'b1;
      if (pkt_done) begin
        pend_st_d = status_q;
        pend_dx_d = pkt_dx;
        pend_dy_d = pkt_dy;
      end else begin
        pend_v_d = 1'b0;
      end
    end else if (pkt_done && !busy) begin
      out_st_d = status_q;
      out_dx_d = pkt_dx;
      out_dy_d = pkt_dy;
      arm_d    = 1'b1;
    end else if (pkt_done) begin
      ovr_evt   = pend_v_q;
      pend_v_d  = 1'b1;
      pend_st_d = status_q;
      pend_dx_d = pkt_dx;
      pend_dy_d = pkt_dy;
    end else begin
      pend_v_d = pend_v_q;
    end

    if ((err_evt || ovr_evt) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    else                                          err_d = err_q;
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      status_q  <= 8'h00;
      dx_q      <= 8'h00;
      tmo_q     <= {TW{1'b0}};
      out_st_q  <= 8'h00;
      out_dx_q  <= 8'h00;
      out_dy_q  <= 8'h00;
      arm_q     <= 1'b0;
      int_q     <= 1'b0;
      icnt_q    <= {IW{1'b0}};
      pend_v_q  <= 1'b0;
      pend_st_q <= 8'h00;
      pend_dx_q <= 8'h00;
      pend_dy_q <= 8'h00;
      err_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      dx_q      <= dx_d;
      tmo_q     <= tmo_d;
      out_st_q  <= out_st_d;
      out_dx_q  <= out_dx_d;
      out_dy_q  <= out_dy_d;
      arm_q     <= arm_d;
      int_q     <= int_d;
      icnt_q    <= icnt_d;
      pend_v_q  <= pend_v_d;
      pend_st_q <= pend_st_d;
      pend_dx_q <= pend_dx_d;
      pend_dy_q <= pend_dy_d;
      err_q     <= err_d;
    end
  end

  assign MOUSE_STATUS   = out_st_q;
  assign MOUSE_DX       = out_dx_q;
  assign MOUSE_DY       = out_dy_q;
  assign INTERRUPT      = int_q;
  assign SYNC_ERR_COUNT = err_q;

endmodule
